// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the CPU data port.
// Accepts one load/store at a time over valid/ready. It waits LATENCY cycles,
// then presents read data and status until the CPU takes the response.
// The word-addressed array is not reset.
//
// Parameters: n (data/address width), ADDR_W (word-index width),
//             LATENCY (0..15 wait cycles)
// Ports:
//   clock, rst            rising-edge clock, async active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_write             1 = store, 0 = load
//   req_addr/req_wdata    byte address / store data
//   req_be                store byte enables (bit i -> byte i)
//   rsp_valid/rsp_ready   response handshake (valid held until ready)
//   rsp_rdata/rsp_err     load data (0 on store/fault) / fault flag
// Build option: define DATA_MEM_RANGE_CHECK_EN to fault on any nonzero address bits
// above the array. Without it, addresses wrap modulo 2**(ADDR_W+2).
module data_mem_responder #(
    parameter int unsigned n       = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    input  logic [3:0]   req_be,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_rdata,
    output logic         rsp_err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               lat_write;
    logic [n-1:0]       lat_addr;
    logic [n-1:0]       lat_wdata;
    logic [3:0]         lat_be;

    logic [n-1:0]       mem [DEPTH];

    logic               op_write_c;
    logic [n-1:0]       op_addr_c;
    logic [n-1:0]       op_wdata_c;
    logic [3:0]         op_be_c;
    logic [ADDR_W-1:0]  op_idx_c;
    logic               range_err_c;
    logic               op_err_c;
    logic               enter_resp_c;
    logic               mem_we_c;

    // With LATENCY==0 the array is accessed on the accept edge, before the
    // latched copy exists, so the live request is used in IDLE.
    always_comb begin
        op_write_c = lat_write;
        op_addr_c  = lat_addr;
        op_wdata_c = lat_wdata;
        op_be_c    = lat_be;
        if (state == IDLE) begin
            op_write_c = req_write;
            op_addr_c  = req_addr;
            op_wdata_c = req_wdata;
            op_be_c    = req_be;
        end
    end

    assign op_idx_c = op_addr_c[ADDR_W+1:2];

`ifdef DATA_MEM_RANGE_CHECK_EN
    assign range_err_c = |op_addr_c[n-1:ADDR_W+2];
`else
    // Upper address bits alias; keep them visibly consumed.
    logic unused_upper_c;
    assign unused_upper_c = ^op_addr_c[n-1:ADDR_W+2];
    assign range_err_c    = 1'b0;
`endif

    assign op_err_c = (op_addr_c[1:0] != 2'b00) || range_err_c;

    // The edge that enters RESP is the one that touches the array.
    assign enter_resp_c = ((state == IDLE) && req_valid && (LATENCY == 0)) ||
                          ((state == WAIT) && (cnt == CNT_W'(1)));

    // Gated by rst so a reset coinciding with the access edge drops the store.
    assign mem_we_c = enter_resp_c && op_write_c && !op_err_c && !rst;

    // Byte-masked array write.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be_c[b]) begin
                    mem[op_idx_c][8*b +: 8] <= op_wdata_c[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= CNT_W'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= (LATENCY == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase

            if (enter_resp_c) begin
                rsp_valid <= 1'b1;
                rsp_err   <= op_err_c;
                rsp_rdata <= (op_write_c || op_err_c) ? '0 : mem[op_idx_c];
            end
        end
    end

endmodule
